fifo_wr_rr_arbiter: RTL
=======================

// Module: fifo_wr_rr_arbiter
// PURPOSE
//  Round-robin write-side arbiter sharing one spram_fifo among NUM_REQ producers.
//  Grants one requester at a time and holds the grant for a whole burst, ending at 'last' or after MAX_BURST beats.
//  Sits between the producers and spram_fifo wen/wdata/full; the read side of the FIFO is untouched.
// PARAMETERS
//  NUM_REQ    4  number of producers (>=2)
//  DATA_WIDTH 8  FIFO data width
//  MAX_BURST  8  max accepted beats per grant before forced release (>=1)
//  IDX_W      $clog2(NUM_REQ)  owner index width (derived)
// PORTS
//  clk         in   1                     clock, all state on rising edge
//  rst_n       in   1                     synchronous reset, active-low
//  req         in   NUM_REQ               per-producer beat valid
//  last        in   NUM_REQ               per-producer final-beat flag, qualified by req
//  wdata_in    in   NUM_REQ*DATA_WIDTH    producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
//  gnt         out  NUM_REQ               one-hot: beat of producer i accepted this cycle
//  fifo_full   in   1                     spram_fifo full
//  fifo_wen    out  1                     spram_fifo write enable
//  fifo_wdata  out  DATA_WIDTH            spram_fifo write data
//  owner       out  IDX_W                 current grant holder, valid when busy=1
//  busy        out  1                     1 while in BURST
// BEHAVIOUR
//  State: IDLE/BURST; regs owner, rr_ptr (IDX_W), beat_cnt ($clog2(MAX_BURST+1)).
//  Reset (rst_n=0 at edge): state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
//  While rst_n=0: gnt=0, fifo_wen=0 combinationally, even if state is still BURST.
//  IDLE: no writes. If |req: winner = first i with req[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   On the edge: owner<=winner, beat_cnt<=0, ->BURST. One-cycle arbitration bubble per burst.
//  BURST: accept = req[owner] & ~fifo_full (combinational, same cycle).
//   fifo_wen=accept; gnt=accept<<owner; fifo_wdata=wdata_in[owner] always (don't-care when wen=0).
//   On accept: beat_cnt++; if last[owner] or beat_cnt+1==MAX_BURST, then ->IDLE, rr_ptr<=(owner+1) mod NUM_REQ.
//   No accept (full or req[owner]=0): hold state/owner/beat_cnt; no write, no gnt. No timeout.
//  last is ignored when req=0; last on the first beat gives a 1-beat burst.
//  Producers hold data stable until gnt; a beat is consumed only in a cycle with gnt[i]=1.
//  busy = (state==BURST); owner output = owner reg.
//  Non-owners never see gnt. A request arriving during a burst waits for IDLE.
//  Forced release at MAX_BURST: the producer keeps req and re-arbitrates normally, last-priority.
//  No combinational path from fifo_full to req; producers must not gate req on gnt.
// TESTING
//  1 P0 req 3 beats (10,11,12, last on 12), others idle -> 1 IDLE cycle, then wen 3 consecutive
//    cycles, wdata 10/11/12, gnt=0001 each, busy drops, rr_ptr=1.
//  2 all 4 req from reset, 2-beat bursts -> owners 0,1,2,3,0; each burst = 1 bubble + 2 wen cycles;
//    gnt always one-hot.
//  3 P2 burst, fifo_full=1 for 2 cycles after beat 1 -> wen=0, gnt=0 those cycles; owner=2 held;
//    beat 2 written with unchanged data after full drops.
//  4 P0 continuous req, never last (MAX_BURST=8), P1 req -> release after 8 beats; P1 granted next;
//    P0 regains only after P1.
//  5 rst_n=0 mid-burst of P3 -> wen=0 and gnt=0 in the reset cycle; then IDLE, rr_ptr=0, busy=0;
//    next grant goes to the lowest req index.
//  6 P1 drops req mid-burst for 3 cycles, P0 req -> no wen, owner stays 1; P1 resumes and finishes
//    its burst; P0 is granted afterwards.

Source files
------------

// File: rtl/fifo_wr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_rr_arbiter
//   Round-robin write-side arbiter that lets NUM_REQ producers share the write
//   port of one spram_fifo. A producer wins in IDLE, then owns the FIFO for a
//   whole burst. The burst ends on its 'last' beat or after MAX_BURST accepted
//   beats, whichever comes first. Every burst costs one arbitration bubble.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   req, last    per-producer beat valid / final-beat flag (last qualified by req)
//   wdata_in     producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt          one-hot, beat of producer i accepted this cycle
//   fifo_full    FIFO back-pressure
//   fifo_wen     FIFO write enable
//   fifo_wdata   FIFO write data (owner's data, don't-care when fifo_wen=0)
//   owner        current grant holder, valid while busy=1
//   busy         high while a burst is in progress
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no owner; pick next requester round-robin from rr_ptr
// ST_BURST | owner_q may write one beat per cycle when not full
// ---------------------------------------------------------------------------
module fifo_wr_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 8,
   parameter int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in,
   output logic [NUM_REQ-1:0]            gnt,
   input  logic                          fifo_full,
   output logic                          fifo_wen,
   output logic [DATA_WIDTH-1:0]         fifo_wdata,
   output logic [IDX_W-1:0]              owner,
   output logic                          busy
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t              state_q;
   logic [IDX_W-1:0]    owner_q;
   logic [IDX_W-1:0]    rr_ptr_q;
   logic [CNT_W-1:0]    beat_cnt_q;

   logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
   logic [IDX_W-1:0]      winner;
   logic [IDX_W-1:0]      owner_inc;
   logic                  accept;
   logic                  burst_end;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign wdata_arr[i] = wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // First requester at or after ptr, wrapping. Scanning from the far end
   // lets the closest candidate overwrite the others, so no early exit needed.
   function automatic logic [IDX_W-1:0] rr_pick(
      input logic [NUM_REQ-1:0] r,
      input logic [IDX_W-1:0]   ptr
   );
      logic [IDX_W-1:0]   pick;
      logic [NUM_REQ-1:0] sh;
      int                 cand;
      pick = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         sh = r >> cand;
         if (sh[0]) pick = IDX_W'(cand);
      end
      return pick;
   endfunction

   assign winner    = rr_pick(req, rr_ptr_q);
   assign owner_inc = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
   assign accept    = (state_q == ST_BURST) && req[owner_q] && !fifo_full;
   assign burst_end = last[owner_q] || ((int'(beat_cnt_q) + 1) == MAX_BURST);

   // Reset masks the write strobe combinationally so a burst caught by reset
   // cannot push one more beat into the FIFO on the reset edge.
   assign fifo_wen   = accept && rst_n;
   assign gnt        = fifo_wen ? (NUM_REQ'(1) << owner_q) : '0;
   assign fifo_wdata = wdata_arr[owner_q];
   assign owner      = owner_q;
   assign busy       = (state_q == ST_BURST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (|req) begin
                  owner_q    <= winner;
                  beat_cnt_q <= '0;
                  state_q    <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (accept) begin
                  beat_cnt_q <= beat_cnt_q + 1'b1;
                  if (burst_end) begin
                     state_q  <= ST_IDLE;
                     rr_ptr_q <= owner_inc;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
